sha_round_iter: RTL and testbench
=================================

# sha_round_iter

Iterative SHA-256 compression engine: accepts one 8-word chaining state plus one 512-bit message block, runs all 64 rounds over `64/UNROLL` clock cycles with UNROLL combinationally chained rounds per cycle, and returns the updated chaining state. It is the parametrised successor to the single registered round stage. It adds:
- internal K constants and an internal message schedule;
- a valid/ready handshake on both sides;
- an optional feed-forward add.

It sits between the block-padding front end and the digest/nonce-compare logic.

## Interface
- UNROLL, 1: rounds evaluated per clock; legal values 1, 2, 4, 8 (must divide 64).
- FEEDFORWARD, 1: 1 = output is per-word `init + work` mod 2^32; 0 = output is the raw working state after round 63.

- clk  in  1  rising-edge clock.
- reset_n  in  1  reset; one clock; asynchronous, active-low.
- in_valid  in  1  input state/block offered.
- in_ready  out  1  engine can accept; equals (state==IDLE).
- in_state  in  256  chaining state; word a in [255:224] … word h in [31:0].
- in_block  in  512  message block; W0 in [511:480] … W15 in [31:0].
- out_valid  out  1  out_state holds a result.
- out_ready  in  1  consumer accepts result.
- out_state  out  256  result, same word order as in_state.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states:
  - IDLE -> RUN on `in_valid && in_ready`.
  - RUN -> DONE when the round counter completes round 63.
  - DONE -> IDLE on `out_ready`.
- Accept edge:
  - load working regs a..h from in_state;
  - copy in_state to an init register;
  - load the 16-word W window from in_block;
  - clear the round counter t (7 bits, steps by UNROLL).
- Each RUN edge applies UNROLL rounds in sequence, using W_t..W_{t+UNROLL-1} and K_t..K_{t+UNROLL-1}. Per round:
  - `T1 = h + Σ1(e) + Ch(e,f,g) + K + W`
  - `T2 = Σ0(a) + Maj(a,b,c)`
  - `h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2`
- All additions are mod 2^32 and drop the carry.
- Σ0 = ROTR2^ROTR13^ROTR22. Σ1 = ROTR6^ROTR11^ROTR25.
- Schedule, for t ≥ 16:
  - `W_t = σ1(W_{t-2}) + W_{t-7} + σ0(W_{t-15}) + W_{t-16}`
  - σ0 = ROTR7^ROTR18^SHR3; σ1 = ROTR17^ROTR19^SHR10.
  - The window shifts by UNROLL words per RUN edge.
  - New words may depend on words generated in the same cycle (chained within the cycle).
- K: 64-entry constant table indexed by t+i, per FIPS 180-4.
- On the final RUN edge (t+UNROLL == 64), out_state is registered with the feed-forward result (or the raw working state) and out_valid is set.
- In DONE, out_state and out_valid hold stable until `out_ready`. On `out_valid && out_ready`, out_valid clears.
- in_valid during RUN/DONE is ignored (in_ready low). Sources hold their data per protocol.
- While out_valid is low, out_state keeps its last value and is not cleared.

## Timing
- Reset (reset_n low, asynchronous):
  - FSM = IDLE, in_ready = 1, busy = 0;
  - out_valid = 0, out_state = 0;
  - round counter = 0.
  - Working, init and W registers are don't-care.
- Latency: out_valid rises on the N-th rising edge after the accept edge, N = 64/UNROLL (64, 32, 16, 8).
- in_ready returns high the cycle after the output handshake edge. Minimum issue interval is N+2 cycles with out_ready held high.
- out_ready is sampled only in DONE. out_ready high with out_valid low has no effect.
- reset_n asserted mid-RUN or in DONE: the block is abandoned and no output is produced. Next accept is possible on the first edge after release.
- No combinational path from in_valid to in_ready or from out_ready to out_valid.

## Test plan
- UNROLL=1, FEEDFORWARD=1, in_state = SHA-256 IV (6a09e667 … 5be0cd19), in_block = padded "abc" -> out_state = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; out_valid exactly 64 edges after accept.
- UNROLL=4, IV + padded empty message (80000000, 14×0, 00000000) -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855; out_valid 16 edges after accept.
- UNROLL=8, FEEDFORWARD=0, "abc" vector -> out_state equals the expected digest minus IV per word mod 2^32; latency 8.
- Backpressure: out_ready low for 20 cycles after out_valid -> out_state/out_valid stable, in_ready = 0, second in_valid not accepted; then out_ready = 1 -> in_ready high next cycle.
- Reset mid-run: assert reset_n low at round 30 -> out_valid stays 0, in_ready = 1 immediately. Re-issue "abc" -> correct digest.
- Back-to-back two-block message (448-bit "abcdbcdecdefdefg…nopq" padded): second block uses first result as in_state -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.

Source files
------------

// File: rtl/sha_round_iter.sv
`default_nettype none
// ============================================================================
// Module   : sha_round_iter
// Purpose  : Iterative SHA-256 compression, UNROLL chained rounds per clock.
// Revision : 1.0
// ============================================================================
module sha_round_iter #(
    parameter int UNROLL      = 1,
    parameter int FEEDFORWARD = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] in_state,
    input  logic [511:0] in_block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_state,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [6:0] C_STEP   = 7'(UNROLL);
    localparam logic [6:0] C_LAST_T = 7'(64 - UNROLL);

    localparam logic [31:0] C_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Working state is packed a..h from MSB to LSB, same order as in_state.
    function automatic logic [255:0] sha_round(input logic [255:0] s,
                                               input logic [31:0]  k,
                                               input logic [31:0]  w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + bsig1(e) + ((e & f) ^ (~e & g)) + k + w;
        t2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    state_t       state_q, state_d;
    logic [6:0]   t_q, t_d;
    logic         out_valid_q, out_valid_d;
    logic [255:0] out_state_q, out_state_d;
    logic [255:0] work_q, work_d;
    logic [255:0] init_q, init_d;
    logic [511:0] sched_q, sched_d;

    logic [31:0]  w_ext [0:15+UNROLL];
    logic [511:0] w_sched_next;
    logic [255:0] w_chain;
    logic [255:0] w_result;

    // Schedule extension and round chain; new words may feed later words
    // generated in the same cycle.
    always_comb begin
        for (int j = 0; j < 16; j++) begin
            w_ext[j] = sched_q[511 - 32*j -: 32];
        end
        for (int j = 0; j < UNROLL; j++) begin
            w_ext[16+j] = ssig1(w_ext[14+j]) + w_ext[9+j] + ssig0(w_ext[1+j]) + w_ext[j];
        end
        w_sched_next = '0;
        for (int j = 0; j < 16; j++) begin
            w_sched_next[511 - 32*j -: 32] = w_ext[j+UNROLL];
        end
        w_chain = work_q;
        for (int i = 0; i < UNROLL; i++) begin
            w_chain = sha_round(w_chain, C_K[t_q[5:0] + 6'(i)], w_ext[i]);
        end
    end

    generate
        if (FEEDFORWARD != 0) begin : g_ff_add
            for (genvar i = 0; i < 8; i++) begin : g_word
                assign w_result[32*i +: 32] = init_q[32*i +: 32] + w_chain[32*i +: 32];
            end
        end else begin : g_ff_raw
            logic w_unused_init;
            assign w_unused_init = ^init_q;
            assign w_result      = w_chain;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        out_valid_d = out_valid_q;
        out_state_d = out_state_q;
        work_d      = work_q;
        init_d      = init_q;
        sched_d     = sched_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                    work_d  = in_state;
                    init_d  = in_state;
                    sched_d = in_block;
                    t_d     = '0;
                end
            end
            RUN: begin
                work_d  = w_chain;
                sched_d = w_sched_next;
                t_d     = t_q + C_STEP;
                if (t_q == C_LAST_T) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_state_d = w_result;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            t_q         <= '0;
            out_valid_q <= 1'b0;
            out_state_q <= '0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            out_valid_q <= out_valid_d;
            out_state_q <= out_state_d;
        end
    end

    // Datapath registers carry no reset; they are always loaded on accept.
    always_ff @(posedge clk) begin
        work_q  <= work_d;
        init_q  <= init_d;
        sched_q <= sched_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_state = out_state_q;

endmodule
`default_nettype wire

// File: tb/tb_sha_round_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha_round_iter
// Purpose  : Self-checking bench for sha_round_iter (UNROLL 1/4/8 instances).
// Revision : 1.0
// ============================================================================
module tb_sha_round_iter;

    localparam logic [255:0] IV        = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_TWO_1 = {256'h6162636462636465636465666465666765666768666768696768696a68696a6b,
                                          192'h696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f7071,
                                          32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_TWO_2 = {480'h0, 32'h000001c0};
    localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    localparam int N_TAB  [3] = '{64, 16, 8};
    localparam bit FF_TAB [3] = '{1'b1, 1'b1, 1'b0};

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk;
    logic         reset_n;
    logic         in_valid_v  [3];
    logic         in_ready_v  [3];
    logic         out_valid_v [3];
    logic         out_ready_v [3];
    logic         busy_v      [3];
    logic [255:0] in_state_v  [3];
    logic [511:0] in_block_v  [3];
    logic [255:0] out_state_v [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sha_round_iter #(.UNROLL(1), .FEEDFORWARD(1)) u_dut_u1 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .in_state(in_state_v[0]), .in_block(in_block_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .out_state(out_state_v[0]), .busy(busy_v[0])
    );

    sha_round_iter #(.UNROLL(4), .FEEDFORWARD(1)) u_dut_u4 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .in_state(in_state_v[1]), .in_block(in_block_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .out_state(out_state_v[1]), .busy(busy_v[1])
    );

    sha_round_iter #(.UNROLL(8), .FEEDFORWARD(0)) u_dut_u8 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .in_state(in_state_v[2]), .in_block(in_block_v[2]),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .out_state(out_state_v[2]), .busy(busy_v[2])
    );

    // Reference: textbook SHA-256 compression over a full 64-word schedule.
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] ref_compress(input logic [255:0] st, input logic [511:0] blk, input bit ff);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        for (int i = 0; i < 8; i++) v[i] = st[255 - 32*i -: 32];
        for (int i = 0; i < 64; i++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TAB[i] + w[i];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++)
            r[255 - 32*i -: 32] = ff ? st[255 - 32*i -: 32] + v[i] : v[i];
        return r;
    endfunction

    function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic checkb(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Called #1 after a rising edge; returns with the same phase after the output handshake.
    task automatic run_block(input int idx, input logic [255:0] st, input logic [511:0] blk,
                             input logic [255:0] expv, input string tag,
                             output int acc_cyc, output logic [255:0] res);
        int wt;
        int lat;
        wt = 0;
        while (in_ready_v[idx] !== 1'b1 && wt < 200) begin
            @(posedge clk); #1;
            wt++;
        end
        in_state_v[idx]  = st;
        in_block_v[idx]  = blk;
        in_valid_v[idx]  = 1'b1;
        out_ready_v[idx] = 1'b1;
        @(posedge clk); #1;
        acc_cyc         = cyc;
        in_valid_v[idx] = 1'b0;
        checkb({tag, " busy"}, busy_v[idx], 1'b1);
        lat = 0;
        while (out_valid_v[idx] !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        checki({tag, " latency"}, lat, N_TAB[idx]);
        check({tag, " out_state"}, out_state_v[idx], expv);
        res = out_state_v[idx];
        @(posedge clk); #1;
        checkb({tag, " in_ready after hs"}, in_ready_v[idx], 1'b1);
        checkb({tag, " out_valid after hs"}, out_valid_v[idx], 1'b0);
    endtask

    initial begin
        logic [255:0] res1, res2, hold, expv, st;
        logic [511:0] blk;
        int           acc1, acc2, lat;
        logic         seen;

        reset_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid_v[k]  = 1'b0;
            out_ready_v[k] = 1'b0;
            in_state_v[k]  = '0;
            in_block_v[k]  = '0;
        end
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            checkb("reset in_ready", in_ready_v[k], 1'b1);
            checkb("reset busy", busy_v[k], 1'b0);
            checkb("reset out_valid", out_valid_v[k], 1'b0);
            check("reset out_state", out_state_v[k], '0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Known-answer vectors
        run_block(0, IV, BLK_ABC, DIG_ABC, "u1 abc", acc1, res1);
        run_block(1, IV, BLK_EMPTY, DIG_EMPTY, "u4 empty", acc1, res1);
        expv = ref_compress(IV, BLK_ABC, 1'b0);
        run_block(2, IV, BLK_ABC, expv, "u8 raw abc", acc1, res1);
        check("u8 raw abc plus iv", add_words(res1, IV), DIG_ABC);

        // Two-block message, second block issued as soon as in_ready returns
        run_block(1, IV, BLK_TWO_1, ref_compress(IV, BLK_TWO_1, 1'b1), "u4 two blk1", acc1, res1);
        run_block(1, res1, BLK_TWO_2, DIG_TWO, "u4 two blk2", acc2, res2);
        checki("u4 issue interval", acc2 - acc1, 18);

        // Backpressure: result held for 20 cycles while a second offer is ignored
        st   = rand256();
        blk  = rand512();
        expv = ref_compress(st, blk, 1'b1);
        in_state_v[1]  = st;
        in_block_v[1]  = blk;
        in_valid_v[1]  = 1'b1;
        out_ready_v[1] = 1'b0;
        @(posedge clk); #1;
        in_valid_v[1] = 1'b0;
        lat = 0;
        while (out_valid_v[1] !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        checki("bp latency", lat, 16);
        hold = out_state_v[1];
        check("bp result", hold, expv);
        for (int c = 0; c < 20; c++) begin
            in_state_v[1] = rand256();
            in_block_v[1] = rand512();
            in_valid_v[1] = 1'b1;
            @(posedge clk); #1;
            checkb("bp out_valid held", out_valid_v[1], 1'b1);
            check("bp out_state held", out_state_v[1], hold);
            checkb("bp in_ready low", in_ready_v[1], 1'b0);
        end
        in_valid_v[1]  = 1'b0;
        out_ready_v[1] = 1'b1;
        @(posedge clk); #1;
        checkb("bp in_ready after release", in_ready_v[1], 1'b1);
        checkb("bp out_valid cleared", out_valid_v[1], 1'b0);
        checkb("bp second offer dropped", busy_v[1], 1'b0);
        check("bp out_state kept", out_state_v[1], hold);

        // Reset in the middle of a run abandons the block
        in_state_v[0]  = IV;
        in_block_v[0]  = BLK_ABC;
        in_valid_v[0]  = 1'b1;
        out_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkb("midrst in_ready", in_ready_v[0], 1'b1);
        checkb("midrst busy", busy_v[0], 1'b0);
        checkb("midrst out_valid", out_valid_v[0], 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            if (out_valid_v[0] === 1'b1) seen = 1'b1;
        end
        checkb("midrst no output", seen, 1'b0);
        run_block(0, IV, BLK_ABC, DIG_ABC, "u1 abc after reset", acc1, res1);

        // Random blocks against the reference model
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 3; r++) begin
                st  = rand256();
                blk = rand512();
                run_block(k, st, blk, ref_compress(st, blk, FF_TAB[k]), "random", acc1, res1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
